// File: rtl/zrle_comp_param_if.sv
// Stream bundle for the zero-run-length compressor: input beat, output codeword, error control.
interface zrle_comp_param_if #(
  parameter int unsigned SYM_W = 16,
  parameter int unsigned NSYM  = 4
);
  localparam int unsigned IN_W  = NSYM * SYM_W;
  localparam int unsigned OUT_W = 3 + NSYM + IN_W;
  localparam int unsigned SZ_W  = $clog2(OUT_W + 1);

  logic [IN_W-1:0]  data_i;
  logic             valid_i;
  logic             ready_o;
  logic             sop_i;
  logic             eop_i;
  logic             bypass_i;
  logic             clr_err_i;
  logic [OUT_W-1:0] data_o;
  logic [SZ_W-1:0]  size_o;
  logic             valid_o;
  logic             sop_o;
  logic             eop_o;
  logic             ready_i;
  logic             err_o;

  // Compressor side
  modport slave (
    input  data_i, valid_i, sop_i, eop_i, bypass_i, clr_err_i, ready_i,
    output ready_o, data_o, size_o, valid_o, sop_o, eop_o, err_o
  );

  // Producer/consumer side
  modport master (
    output data_i, valid_i, sop_i, eop_i, bypass_i, clr_err_i, ready_i,
    input  ready_o, data_o, size_o, valid_o, sop_o, eop_o, err_o
  );
endinterface

// File: rtl/zrle_comp_param.sv
// Zero-run-length beat compressor: mask or escape codeword, optional SOP prefix,
// one-cycle registered output with skid-free ready, and packet framing checker.
module zrle_comp_param #(
  parameter int unsigned SYM_W = 16,
  parameter int unsigned NSYM  = 4
) (
  input logic               clk,
  input logic               rst_n,
  zrle_comp_param_if.slave  bus
);
  localparam int unsigned IN_W  = NSYM * SYM_W;
  localparam int unsigned OUT_W = 3 + NSYM + IN_W;
  localparam int unsigned SZ_W  = $clog2(OUT_W + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  logic [NSYM-1:0]  nz_c;
  logic             escape_c;
  logic [OUT_W-1:0] body_c;
  logic [SZ_W-1:0]  len_c;
  logic [OUT_W-1:0] cw_c;
  logic             accept_c;

  logic [0:0]       state_q, state_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [SZ_W-1:0]  size_q, size_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;

  assign bus.ready_o = !valid_q || bus.ready_i;
  assign accept_c    = bus.valid_i && bus.ready_o;

  // Build the codeword LSB-aligned while counting its length, then MSB-align it
  always_comb begin
    nz_c = '0;
    for (int unsigned k = 0; k < NSYM; k++) begin
      nz_c[k] = |bus.data_i[k*SYM_W +: SYM_W];
    end
    escape_c = (&nz_c) || bus.bypass_i;
    body_c   = '0;
    len_c    = '0;
    if (bus.sop_i) begin
      body_c = OUT_W'(2'b01);
      len_c  = SZ_W'(2);
    end
    if (escape_c) begin
      body_c = (body_c << (1 + IN_W)) | OUT_W'({1'b1, bus.data_i});
      len_c  = len_c + SZ_W'(1 + IN_W);
    end else begin
      body_c = (body_c << (1 + NSYM)) | OUT_W'({1'b0, nz_c});
      len_c  = len_c + SZ_W'(1 + NSYM);
      for (int unsigned j = 0; j < NSYM; j++) begin
        if (nz_c[NSYM-1-j]) begin
          body_c = (body_c << SYM_W) | OUT_W'(bus.data_i[(NSYM-1-j)*SYM_W +: SYM_W]);
          len_c  = len_c + SZ_W'(SYM_W);
        end
      end
    end
    cw_c = body_c << (SZ_W'(OUT_W) - len_c);
  end

  // Next-state: output register load/drain, framing FSM, sticky error
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    valid_d = valid_q;
    data_d  = data_q;
    size_d  = size_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (bus.clr_err_i) begin
      err_d = 1'b0;
    end
    if (accept_c) begin
      valid_d = 1'b1;
      data_d  = cw_c;
      size_d  = len_c;
      sop_d   = bus.sop_i;
      eop_d   = bus.eop_i;
      case (state_q)
        IDLE: begin
          if (bus.sop_i) begin
            state_d = bus.eop_i ? IDLE : IN_PKT;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          if (bus.sop_i) begin
            err_d   = 1'b1;
            state_d = bus.eop_i ? IDLE : IN_PKT;
          end else if (bus.eop_i) begin
            state_d = IDLE;
          end
        end
      endcase
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      size_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      size_q  <= size_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.size_o  = size_q;
  assign bus.valid_o = valid_q;
  assign bus.sop_o   = sop_q;
  assign bus.eop_o   = eop_q;
  assign bus.err_o   = err_q;
endmodule
